fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: one req/ack read per instruction, held for decode until consumed.
// Optional FETCH_ALIGN_CHK_EN: odd PC yields an error NOP without touching memory.
module fetch_unit #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  input  logic        Redirect,
  input  logic        Halt,
  input  logic        IdStall,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] Instr,
  output logic [15:0] InstrPc,
  output logic        InstrValid,
  output logic        PcStall,
  output logic        Err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic       TIMEOUT_EN = (MAX_WAIT != 32'd0);
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 32'd1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        drop_q, drop_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        req_d;
  logic [15:0] maddr_d;
  logic        timeout;
  logic        discard;

  // wcnt_q holds (WAIT cycles elapsed - 1) during the current WAIT cycle
  assign timeout = TIMEOUT_EN && (wcnt_q == WAIT_LAST);
  assign discard = drop_q || Redirect;

  // Next-state and next-register computation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    drop_d  = drop_q;
    wcnt_d  = wcnt_q;
    req_d   = 1'b0;
    maddr_d = mem_addr;
    case (state_q)
      S_IDLE: begin
        if (Halt) begin
          state_d = S_HALT;
        end else begin
          addr_d = PC;
`ifdef FETCH_ALIGN_CHK_EN
          if (PC[0]) begin
            instr_d = NOP_INSTR;
            err_d   = 1'b1;
            state_d = S_VALID;
          end else begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            maddr_d = PC;
            err_d   = 1'b0;
            wcnt_d  = 8'd0;
          end
`else
          state_d = S_WAIT;
          req_d   = 1'b1;
          maddr_d = {PC[15:1], 1'b0};
          err_d   = 1'b0;
          wcnt_d  = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          drop_d = 1'b0;
          if (discard) begin
            state_d = S_IDLE;
          end else begin
            instr_d = mem_rdata;
            state_d = S_VALID;
          end
        end else if (timeout) begin
          drop_d = 1'b0;
          if (discard) begin
            state_d = S_IDLE;
          end else begin
            instr_d = NOP_INSTR;
            err_d   = 1'b1;
            state_d = S_VALID;
          end
        end else begin
          // Request stays up even after a redirect; the late data is dropped instead
          req_d = 1'b1;
          if (Redirect) begin
            drop_d = 1'b1;
          end else begin
            drop_d = drop_q;
          end
          if (wcnt_q != 8'hFF) begin
            wcnt_d = wcnt_q + 8'd1;
          end else begin
            wcnt_d = wcnt_q;
          end
        end
      end
      S_VALID: begin
        if (Redirect) begin
          state_d = S_IDLE;
        end else if (!IdStall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_VALID;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, including the registered memory request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 16'd0;
      instr_q  <= NOP_INSTR;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      wcnt_q   <= 8'd0;
      mem_req  <= 1'b0;
      mem_addr <= 16'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      wcnt_q   <= wcnt_d;
      mem_req  <= req_d;
      mem_addr <= maddr_d;
    end
  end

  assign Instr      = instr_q;
  assign InstrPc    = addr_q;
  assign Err        = err_q && (state_q == S_VALID);
  assign InstrValid = (state_q == S_VALID) && !Redirect;
  assign PcStall    = !((state_q == S_VALID) && !IdStall);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change on the falling edge, outputs checked 1ns later.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] PC;
  logic        Redirect;
  logic        Halt;
  logic        IdStall;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] Instr;
  logic [15:0] InstrPc;
  logic        InstrValid;
  logic        PcStall;
  logic        Err;

  int n_vec;
  int n_err;

  fetch_unit #(.NOP_INSTR(16'h0800), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Redirect(Redirect), .Halt(Halt),
    .IdStall(IdStall), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .Instr(Instr), .InstrPc(InstrPc),
    .InstrValid(InstrValid), .PcStall(PcStall), .Err(Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; PC = 16'h0000; Redirect = 1'b0; Halt = 1'b0; IdStall = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;

    // reset values
    @(negedge clk); #1;
    chk1 ("rst_req",    mem_req,    1'b0);
    chk16("rst_addr",   mem_addr,   16'h0000);
    chk1 ("rst_valid",  InstrValid, 1'b0);
    chk1 ("rst_stall",  PcStall,    1'b1);
    chk1 ("rst_err",    Err,        1'b0);
    chk16("rst_instr",  Instr,      16'h0800);
    chk16("rst_ipc",    InstrPc,    16'h0000);

    // basic fetch, ack one cycle after req
    @(negedge clk); rst = 1'b1; PC = 16'h0000; #1;
    chk1 ("f0_idle_stall", PcStall, 1'b1);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hC0DE; #1;
    chk1 ("f0_req",   mem_req,    1'b1);
    chk16("f0_addr",  mem_addr,   16'h0000);
    chk1 ("f0_wvld",  InstrValid, 1'b0);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk1 ("f0_valid", InstrValid, 1'b1);
    chk16("f0_instr", Instr,      16'hC0DE);
    chk1 ("f0_stall", PcStall,    1'b0);
    chk1 ("f0_err",   Err,        1'b0);
    chk1 ("f0_req_lo", mem_req,   1'b0);

    // decode stall for three cycles, stray ack ignored
    @(negedge clk); PC = 16'h0002; #1;
    chk1 ("f1_idle_vld", InstrValid, 1'b0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hA5A5; #1;
    chk1 ("f1_req",  mem_req,  1'b1);
    chk16("f1_addr", mem_addr, 16'h0002);
    @(negedge clk); mem_ack = 1'b0; IdStall = 1'b1; #1;
    chk1 ("f1_hold1_vld",   InstrValid, 1'b1);
    chk16("f1_hold1_instr", Instr,      16'hA5A5);
    chk1 ("f1_hold1_stall", PcStall,    1'b1);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hFFFF; #1;
    chk16("f1_hold2_instr", Instr,   16'hA5A5);
    chk1 ("f1_hold2_req",   mem_req, 1'b0);
    chk1 ("f1_hold2_stall", PcStall, 1'b1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk16("f1_hold3_instr", Instr,      16'hA5A5);
    chk16("f1_hold3_ipc",   InstrPc,    16'h0002);
    chk1 ("f1_hold3_vld",   InstrValid, 1'b1);
    @(negedge clk); IdStall = 1'b0; #1;
    chk1 ("f1_take_stall", PcStall,    1'b0);
    chk1 ("f1_take_vld",   InstrValid, 1'b1);

    // redirect in WAIT, ack two cycles later is dropped
    @(negedge clk); PC = 16'h0004; #1;
    @(negedge clk); Redirect = 1'b1; #1;
    chk1 ("r_req",  mem_req,    1'b1);
    chk16("r_addr", mem_addr,   16'h0004);
    @(negedge clk); Redirect = 1'b0; PC = 16'h0040; #1;
    chk1 ("r_req2",  mem_req,  1'b1);
    chk16("r_addr2", mem_addr, 16'h0004);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h1234; #1;
    chk1 ("r_req3", mem_req, 1'b1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk1 ("r_drop_vld", InstrValid, 1'b0);
    chk1 ("r_drop_req", mem_req,    1'b0);
    chk1 ("r_drop_stall", PcStall,  1'b1);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hBEEF; #1;
    chk1 ("r_new_req",  mem_req,  1'b1);
    chk16("r_new_addr", mem_addr, 16'h0040);
    @(negedge clk); mem_ack = 1'b0; IdStall = 1'b1; #1;
    chk1 ("r_new_vld",   InstrValid, 1'b1);
    chk16("r_new_instr", Instr,      16'hBEEF);
    chk16("r_new_ipc",   InstrPc,    16'h0040);
    // redirect in VALID kills despite decode stall
    @(negedge clk); Redirect = 1'b1; #1;
    chk1 ("k_vld", InstrValid, 1'b0);
    @(negedge clk); Redirect = 1'b0; IdStall = 1'b0; PC = 16'h0010; #1;
    chk1 ("k_idle_vld",   InstrValid, 1'b0);
    chk1 ("k_idle_stall", PcStall,    1'b1);

    // timeout after eight WAIT cycles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk1 ("to_req",  mem_req,  1'b1);
      chk16("to_addr", mem_addr, 16'h0010);
    end
    @(negedge clk); #1;
    chk1 ("to_req_lo", mem_req,    1'b0);
    chk1 ("to_vld",    InstrValid, 1'b1);
    chk16("to_instr",  Instr,      16'h0800);
    chk1 ("to_err",    Err,        1'b1);
    chk16("to_ipc",    InstrPc,    16'h0010);

    // error flag clears on the next fetch
    @(negedge clk); PC = 16'h0012; #1;
    chk1 ("ec_idle_err", Err, 1'b0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h5555; #1;
    chk1 ("ec_req", mem_req, 1'b1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk1 ("ec_vld",   InstrValid, 1'b1);
    chk16("ec_instr", Instr,      16'h5555);
    chk1 ("ec_err",   Err,        1'b0);

    // odd PC
    @(negedge clk); PC = 16'h0003; #1;
`ifdef FETCH_ALIGN_CHK_EN
    @(negedge clk); #1;
    chk1 ("al_req",   mem_req,    1'b0);
    chk1 ("al_vld",   InstrValid, 1'b1);
    chk1 ("al_err",   Err,        1'b1);
    chk16("al_instr", Instr,      16'h0800);
    chk16("al_ipc",   InstrPc,    16'h0003);
`else
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h7777; #1;
    chk1 ("al_req",  mem_req,  1'b1);
    chk16("al_addr", mem_addr, 16'h0002);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk1 ("al_vld",   InstrValid, 1'b1);
    chk1 ("al_err",   Err,        1'b0);
    chk16("al_instr", Instr,      16'h7777);
    chk16("al_ipc",   InstrPc,    16'h0003);
`endif

    // halt is sticky until reset
    @(negedge clk); Halt = 1'b1; PC = 16'h0006; #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); Halt = 1'b0; mem_ack = 1'b1; PC = PC + 16'd2; #1;
      chk1 ("h_req",   mem_req,    1'b0);
      chk1 ("h_stall", PcStall,    1'b1);
      chk1 ("h_vld",   InstrValid, 1'b0);
    end
    @(negedge clk); mem_ack = 1'b0; rst = 1'b0; #1;
    chk1 ("h_rst_stall", PcStall, 1'b1);
    @(negedge clk); rst = 1'b1; PC = 16'h0020; #1;
    @(negedge clk); #1;
    chk1 ("h_out_req",  mem_req,  1'b1);
    chk16("h_out_addr", mem_addr, 16'h0020);

    // reset mid-fetch drops the request at once; a later ack is ignored
    #2; rst = 1'b0; #1;
    chk1 ("mr_req",  mem_req,  1'b0);
    chk16("mr_addr", mem_addr, 16'h0000);
    @(negedge clk); rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h9999; PC = 16'h0022; #1;
    chk1 ("mr_idle_vld", InstrValid, 1'b0);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk1 ("mr_req2",  mem_req,    1'b1);
    chk16("mr_addr2", mem_addr,   16'h0022);
    chk1 ("mr_vld2",  InstrValid, 1'b0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h4321; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    chk1 ("mr_vld3",   InstrValid, 1'b1);
    chk16("mr_instr3", Instr,      16'h4321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
